// File: rtl/complex_tile_mem.sv
// Dual-port tile memory for complex FFT tiles: written as column-group beats, read as a whole tile.
// Define COMPLEX_TILE_MEM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module complex_tile_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int TILE_DIM   = 4,
    parameter int BEAT_COLS  = 2,
    parameter int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int EL_W       = 2 * DATA_WIDTH,
    localparam int BEAT_W     = TILE_DIM * BEAT_COLS * EL_W,
    localparam int TILE_W     = TILE_DIM * TILE_DIM * EL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BEAT_W-1:0]     wr_data,
    output logic                  wr_tile_done,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [TILE_W-1:0]     rd_data
);

    localparam int BEATS = TILE_DIM / BEAT_COLS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {IDLE, FILL} wr_state_e;

    wr_state_e             state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  done_q, done_d;
    logic                  ready_q;

    logic                  beat_acc;
    logic [CNT_W-1:0]      wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr_eff;
    logic [BEATS-1:0]      wr_en;

    logic [BEAT_W-1:0]     rd_bank [BEATS];
    logic                  rd_valid_q;
    logic [TILE_W-1:0]     rd_tile;

    assign beat_acc     = wr_valid && ready_q && !reset;
    assign wr_ready     = ready_q;
    assign wr_tile_done = done_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        wr_addr_d   = wr_addr_q;
        done_d      = 1'b0;
        wr_bank     = beat_cnt_q;
        wr_addr_eff = wr_addr_q;
        case (state_q)
            IDLE: begin
                // Beat 0 takes its address straight from the port.
                wr_bank     = '0;
                wr_addr_eff = wr_addr;
                if (beat_acc) begin
                    wr_addr_d = wr_addr;
                    if (BEATS == 1) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = FILL;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            FILL: begin
                if (beat_acc) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en = '0;
        if (beat_acc) begin
            wr_en[wr_bank] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wr_addr_q  <= wr_addr_d;
            done_q     <= done_d;
            ready_q    <= 1'b1;
            rd_valid_q <= rd_valid;
        end
    end

    for (genvar b = 0; b < BEATS; b++) begin : g_bank
        logic [BEAT_W-1:0] mem [DEPTH];
        logic [BEAT_W-1:0] rd_q;

        // NOTE: storage is deliberately not reset; the read below sees the pre-edge word (read-first).
        always_ff @(posedge clk) begin
            if (wr_en[b]) begin
                mem[wr_addr_eff] <= wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
            end else if (rd_valid) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign rd_bank[b] = rd_q;
    end

    // Sub-bank b row r holds columns b*BEAT_COLS.. of that row; reorder into row-major tile.
    always_comb begin
        rd_tile = '0;
        for (int b = 0; b < BEATS; b++) begin
            for (int r = 0; r < TILE_DIM; r++) begin
                for (int j = 0; j < BEAT_COLS; j++) begin
                    rd_tile[(r*TILE_DIM + b*BEAT_COLS + j)*EL_W +: EL_W] =
                        rd_bank[b][(r*BEAT_COLS + j)*EL_W +: EL_W];
                end
            end
        end
    end

`ifdef COMPLEX_TILE_MEM_OUT_REG_EN
    logic              out_valid_q;
    logic [TILE_W-1:0] out_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= rd_tile;
            end
        end
    end

    assign rd_data_valid = out_valid_q;
    assign rd_data       = out_data_q;
`else
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_tile;
`endif

endmodule

// File: tb/tb_complex_tile_mem.sv
// Directed self-checking bench for complex_tile_mem (default parameters).
// Honours COMPLEX_TILE_MEM_OUT_REG_EN for the expected read latency.
module tb_complex_tile_mem;

    localparam int DW     = 32;
    localparam int TD     = 4;
    localparam int BC     = 2;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;
    localparam int EW     = 2 * DW;
    localparam int BEAT_W = TD * BC * EW;
    localparam int TILE_W = TD * TD * EW;
`ifdef COMPLEX_TILE_MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [TILE_W-1:0] tile_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    beat_t         wr_data;
    logic          wr_tile_done;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    tile_t         rd_data;

    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    done_cnt  = 0;
    tile_t model [DEPTH];

    complex_tile_mem dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_tile_done (wr_tile_done),
        .rd_valid     (rd_valid),
        .rd_addr      (rd_addr),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_tile_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Element k of a beat: real = re_base+k, imag = -(re_base+k) or k.
    function automatic beat_t mk_beat(input int re_base, input bit im_neg);
        beat_t bt;
        for (int k = 0; k < TD * BC; k++) begin
            bt[k*EW +: EW] = {32'(re_base + k), im_neg ? 32'(-(re_base + k)) : 32'(k)};
        end
        return bt;
    endfunction

    function automatic tile_t put_beat(input tile_t t, input int b, input beat_t bt);
        tile_t o = t;
        for (int r = 0; r < TD; r++)
            for (int j = 0; j < BC; j++)
                o[(r*TD + b*BC + j)*EW +: EW] = bt[(r*BC + j)*EW +: EW];
        return o;
    endfunction

    function automatic int first_diff(input tile_t a, input tile_t e);
        for (int i = 0; i < TD * TD; i++)
            if (a[i*EW +: EW] !== e[i*EW +: EW]) return i;
        return -1;
    endfunction

    task automatic write_beat(input logic [AW-1:0] a, input beat_t d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_tile(input logic [AW-1:0] a, output tile_t d, output logic v);
        rd_valid = 1'b1;
        rd_addr  = a;
        @(negedge clk);
        rd_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        v = rd_data_valid;
        d = rd_data;
    endtask

    task automatic cmp_tile(input string name, input logic v, input tile_t got, input tile_t exp);
        int i;
        total_cnt++;
        i = first_diff(got, exp);
        if (v !== 1'b1 || i >= 0) begin
            if (i < 0) i = 0;
            $display("FAIL %s: valid=%b elem%0d got %h expected %h", name, v, i,
                     got[i*EW +: EW], exp[i*EW +: EW]);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({wr_ready, wr_tile_done, rd_data_valid} !== 3'b000) begin
            $display("FAIL reset_ctrl: ready/done/valid=%b expected 000",
                     {wr_ready, wr_tile_done, rd_data_valid});
        end else pass_cnt++;
        total_cnt++;
        if (rd_data !== '0) $display("FAIL reset_data: rd_data[63:0]=%h expected 0", rd_data[63:0]);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (wr_ready !== 1'b0) $display("FAIL ready_first_cycle: got %b expected 0", wr_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL ready_after: got %b expected 1", wr_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        tile_t exp, got;
        logic  v;
        int    d0, idx;
        d0 = done_cnt;
        write_beat(9'h005, mk_beat(0, 1'b1));
        write_beat(9'h005, mk_beat(100, 1'b0));
        total_cnt++;
        if (wr_tile_done !== 1'b1) $display("FAIL done_pulse: got %b expected 1", wr_tile_done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wr_tile_done !== 1'b0) $display("FAIL done_width: got %b expected 0", wr_tile_done);
        else pass_cnt++;
        for (int r = 0; r < TD; r++)
            for (int c = 0; c < TD; c++) begin
                idx = r * BC + (c % BC);
                exp[(r*TD + c)*EW +: EW] = (c < BC) ? {32'(idx), 32'(-idx)} : {32'(100 + idx), 32'(idx)};
            end
        model[9'h005] = exp;
        read_tile(9'h005, got, v);
        cmp_tile("basic_tile", v, got, exp);
        total_cnt++;
        if (got[15*EW +: EW] !== {32'd107, 32'd7})
            $display("FAIL basic_elem33: got %h expected %h", got[15*EW +: EW], {32'd107, 32'd7});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rd_data_valid !== 1'b0 || rd_data !== got)
            $display("FAIL rd_hold: valid=%b data_changed=%b expected valid 0 and held", rd_data_valid, rd_data !== got);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_addr_change();
        tile_t got;
        logic  v;
        int    d0;
        write_beat(9'h1FF, mk_beat(500, 1'b0));
        write_beat(9'h1FF, mk_beat(600, 1'b0));
        model[9'h1FF] = put_beat(put_beat('0, 0, mk_beat(500, 1'b0)), 1, mk_beat(600, 1'b0));
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        write_beat(9'h010, mk_beat(200, 1'b1));
        repeat (3) @(negedge clk);
        write_beat(9'h1FF, mk_beat(300, 1'b1));
        model[9'h010] = put_beat(put_beat('0, 0, mk_beat(200, 1'b1)), 1, mk_beat(300, 1'b1));
        repeat (2) @(negedge clk);
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL gap_done_count: got %0d expected 1", done_cnt - d0);
        else pass_cnt++;
        read_tile(9'h010, got, v);
        cmp_tile("gap_tile_010", v, got, model[9'h010]);
        read_tile(9'h1FF, got, v);
        cmp_tile("gap_untouched_1ff", v, got, model[9'h1FF]);
    endtask

    task automatic test_collision();
        tile_t got1, got2, got;
        logic  v1, v2, v;
        write_beat(9'h020, '0);
        write_beat(9'h020, '0);
        model[9'h020] = '0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 9'h020; wr_data = mk_beat(400, 1'b0);
        rd_valid = 1'b1; rd_addr = 9'h020;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            if (i == 1) wr_valid = 1'b0;
            if (i == 2) rd_valid = 1'b0;
            if (i == LAT) begin v1 = rd_data_valid; got1 = rd_data; end
            if (i == LAT + 1) begin v2 = rd_data_valid; got2 = rd_data; end
        end
        rd_valid = 1'b0;
        cmp_tile("collide_read_first", v1, got1, '0);
        model[9'h020] = put_beat('0, 0, mk_beat(400, 1'b0));
        cmp_tile("collide_next_cycle", v2, got2, model[9'h020]);
        write_beat(9'h020, mk_beat(800, 1'b0));
        model[9'h020] = put_beat(model[9'h020], 1, mk_beat(800, 1'b0));
        @(negedge clk);
        read_tile(9'h020, got, v);
        cmp_tile("collide_full", v, got, model[9'h020]);
    endtask

    task automatic test_reset_mid();
        tile_t got;
        logic  v;
        int    d0, bad;
        beat_t aa;
        aa = {(BEAT_W / 8){8'hAA}};
        d0 = done_cnt;
        write_beat(9'h030, aa);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wr_ready !== 1'b0 || rd_data_valid !== 1'b0 || rd_data !== '0)
            $display("FAIL midreset_outputs: ready=%b valid=%b expected 0 0 and zero data", wr_ready, rd_data_valid);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        write_beat(9'h031, mk_beat(900, 1'b0));
        write_beat(9'h031, mk_beat(950, 1'b1));
        model[9'h031] = put_beat(put_beat('0, 0, mk_beat(900, 1'b0)), 1, mk_beat(950, 1'b1));
        repeat (2) @(negedge clk);
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL midreset_done_count: got %0d expected 1", done_cnt - d0);
        else pass_cnt++;
        read_tile(9'h031, got, v);
        cmp_tile("midreset_tile_031", v, got, model[9'h031]);
        read_tile(9'h030, got, v);
        bad = -1;
        for (int r = 0; r < TD; r++)
            for (int c = 0; c < BC; c++)
                if (got[(r*TD + c)*EW +: EW] !== 64'hAAAA_AAAA_AAAA_AAAA) bad = r * TD + c;
        total_cnt++;
        if (v !== 1'b1 || bad >= 0) begin
            if (bad < 0) bad = 0;
            $display("FAIL midreset_kept_030: valid=%b elem%0d got %h expected aaaaaaaaaaaaaaaa",
                     v, bad, got[bad*EW +: EW]);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        tile_t         exp_q[$];
        tile_t         exp;
        logic [AW-1:0] ra, wa;
        logic          exp_done;
        for (int t = 0; t <= 18; t++) begin
            if (t >= LAT && t - LAT < 16) begin
                exp = exp_q.pop_front();
                cmp_tile($sformatf("b2b_read_%0d", t - LAT), rd_data_valid, rd_data, exp);
            end
            if (t == 16 + LAT) begin
                total_cnt++;
                if (rd_data_valid !== 1'b0) $display("FAIL b2b_valid_end: got %b expected 0", rd_data_valid);
                else pass_cnt++;
            end
            exp_done = (t >= 2 && t <= 16 && t % 2 == 0);
            total_cnt++;
            if (wr_tile_done !== exp_done)
                $display("FAIL b2b_done_t%0d: got %b expected %b", t, wr_tile_done, exp_done);
            else pass_cnt++;
            if (t < 16) begin
                ra = (t < 2) ? 9'h005 : AW'(9'h040 + t / 2 - 1);
                wa = AW'(9'h040 + t / 2);
                exp_q.push_back(model[ra]);
                rd_valid = 1'b1; rd_addr = ra;
                wr_valid = 1'b1; wr_addr = wa; wr_data = mk_beat(1000 + 20 * t, t % 2 == 1);
                model[wa] = put_beat(model[wa], t % 2, mk_beat(1000 + 20 * t, t % 2 == 1));
            end else begin
                rd_valid = 1'b0;
                wr_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        test_reset();
        test_basic();
        test_addr_change();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
